nios2_debug_ocimem_sequencer: RTL
=================================

// Module: nios2_debug_ocimem_sequencer
// PURPOSE
// - Sits directly downstream of the CPU debug-slave wrapper, in the clk domain.
// - Decodes its take_action_ocimem_a/b and take_no_action_ocimem_a strobes plus the jdo field.
// - Runs each command as one Avalon-MM master transfer on the debug memory port.
// - Returns MonDReg, monitor_ready and monitor_error, which feed back into the wrapper for JTAG capture.
// PARAMETERS
// - ADDR_W       9    word-address width of avm_address
// - TIMEOUT_CYC  255  cycles allowed per transfer (waitrequest plus readdatavalid) before abort; must be >=2
// PORTS
// - clk                      in   1       system clock, all logic rising-edge
// - reset                    in   1       asynchronous, active-high reset
// - jdo                      in   38      debug-slave data; valid only in the cycle a strobe is high
// - take_action_ocimem_a     in   1       load address; may also start a read
// - take_no_action_ocimem_a  in   1       read at current address
// - take_action_ocimem_b     in   1       write at current address
// - avm_address              out  ADDR_W  word address
// - avm_read                 out  1       read request
// - avm_write                out  1       write request
// - avm_writedata            out  32      write data
// - avm_waitrequest          in   1       slave stall
// - avm_readdata             in   32      read data
// - avm_readdatavalid        in   1       read data strobe
// - MonDReg                  out  32      last read data, or last write data
// - monitor_ready            out  1       sequencer idle, last command completed
// - monitor_error            out  1       sticky error flag
// BEHAVIOUR
// - Reset (async, immediate):
//   - IDLE; avm_read/avm_write=0; avm_address=0; avm_writedata=0.
//   - MonDReg=0; monitor_ready=1; monitor_error=0; timeout counter=0.
// - States: IDLE, RD_REQ, RD_DATA, WR_REQ.
// - Strobes are sampled only in IDLE. Priority: ocimem_a > ocimem_b > no_action_a.
//   Only the winning strobe executes; the others are discarded without error.
// - ocimem_a:
//   - avm_address <= jdo[17+ADDR_W-1:17].
//   - jdo[35]=1 -> RD_REQ, else stay IDLE (address load only).
//   - monitor_error <= 0; this is the only non-reset clear.
// - no_action_a: -> RD_REQ at the current address.
// - ocimem_b: avm_writedata <= jdo[34:3]; MonDReg <= jdo[34:3]; -> WR_REQ.
// - Accepting any command: monitor_ready <= 0 in the next cycle; timeout counter <= 0.
//   An address-only load leaves monitor_ready at 1.
// - RD_REQ:
//   - avm_read=1 from the first cycle in the state; address and data held stable.
//   - Leave on the first edge with avm_waitrequest=0 -> RD_DATA.
//   - If readdatavalid arrives in that same cycle: capture it and complete.
// - RD_DATA: on avm_readdatavalid, MonDReg <= avm_readdata -> completion.
// - WR_REQ: avm_write=1 until an edge with avm_waitrequest=0 -> completion.
// - Completion:
//   - avm_address <= avm_address+1, wrapping modulo 2^ADDR_W.
//   - monitor_ready <= 1; -> IDLE.
//   - Minimum latency, zero-wait slave: write 1 cycle strobe->request, ready 2 cycles after strobe.
//     Read with same-cycle data: also 2 cycles.
// - Timeout:
//   - Counter increments each non-IDLE cycle.
//   - On reaching TIMEOUT_CYC-1 without completion: drop avm_read/avm_write; monitor_error <= 1;
//     monitor_ready <= 1; MonDReg <= 32'hDEADDEAD; address not incremented; -> IDLE.
//   - Completion in that same cycle wins over timeout.
// - Strobe while busy (not IDLE): ignored; monitor_error <= 1 (overrun); the transfer in flight is unaffected.
// - Late readdatavalid while IDLE: ignored; no state change.
// - Reset mid-transfer: the request drops asynchronously; the slave side must tolerate the abandoned read.
// STRUCTURE
// - Shared package nios2_debug_pkg:
//   - state encoding localparams (2 bits);
//   - jdo field positions (ADDR_LSB=17, RD_FLAG=35, WDATA_MSB=34, WDATA_LSB=3);
//   - the 32'hDEADDEAD error pattern.
// - One sub-module: nios2_debug_timeout_ctr.
//   - Ports: clear, enable; output expired.
//   - Width $clog2(TIMEOUT_CYC).
// - Everything else lives in this module: one state register block and one output/datapath block.
// TESTING
// - Read after address load:
//   - Stimulus: ocimem_a with jdo[25:17]=9'h010, jdo[35]=1; slave returns 32'h12345678 with no wait.
//   - Required: avm_address=0x010 on the read; MonDReg=32'h12345678;
//     monitor_ready=1 two cycles after the strobe; address then 0x011.
// - Write with stall:
//   - Stimulus: ocimem_b with jdo[34:3]=32'hCAFEF00D; avm_waitrequest held high for 3 cycles.
//   - Required: avm_write high exactly 4 cycles with data stable; ready after release.
// - Address wrap:
//   - Stimulus: load address 9'h1FF, then no_action_a.
//   - Required: read at 0x1FF; the next address is 0x000.
// - Timeout:
//   - Stimulus: read with readdatavalid never asserted, TIMEOUT_CYC=8.
//   - Required: avm_read drops; after 7 non-IDLE cycles monitor_error=1 and MonDReg=32'hDEADDEAD;
//     a following ocimem_a clears the error.
// - Overrun and priority:
//   - Stimulus 1: ocimem_b during a stalled read.
//     Required: write ignored; error=1.
//   - Stimulus 2: ocimem_a and ocimem_b in the same IDLE cycle.
//     Required: only the address load executes.
// - Async reset mid-read:
//   - Stimulus: assert reset between clock edges in RD_DATA.
//   - Required: avm_read=0 and all outputs at their reset values before the next edge.

Source files
------------

// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug OCI memory sequencer: state encoding,
// jdo field positions and the abort pattern reported on MonDReg.
package nios2_debug_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_RD_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_RD_DATA_ENC = 2'd2;
    localparam logic [1:0] ST_WR_REQ_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_RD_REQ  = ST_RD_REQ_ENC,
        ST_RD_DATA = ST_RD_DATA_ENC,
        ST_WR_REQ  = ST_WR_REQ_ENC
    } seq_state_e;

    localparam int unsigned JDO_W     = 38;
    localparam int unsigned ADDR_LSB  = 17;
    localparam int unsigned RD_FLAG   = 35;
    localparam int unsigned WDATA_MSB = 34;
    localparam int unsigned WDATA_LSB = 3;
    localparam int unsigned DATA_W    = 32;

    localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEADDEAD;

endpackage

// File: rtl/nios2_debug_timeout_ctr.sv
// Per-transfer cycle counter; expired_o is high in the last busy cycle a transfer may
// still complete in (count TIMEOUT_CYC-2), so the abort edge lands on TIMEOUT_CYC-1.
module nios2_debug_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expired_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= (LIMIT == '0);
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/nios2_debug_ocimem_sequencer.sv
// Debug memory sequencer: turns OCI memory strobes from the debug-slave wrapper into
// single Avalon-MM transfers and reports MonDReg/ready/error back for JTAG capture.
module nios2_debug_ocimem_sequencer
    import nios2_debug_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic busy_c;
    logic any_strobe_c;
    logic done_c;
    logic ctr_clear_c;
    logic expired_c;
    logic unused_jdo_c;

    assign busy_c       = (state_q != ST_IDLE);
    assign any_strobe_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo_c = ^{jdo[JDO_W-1:RD_FLAG+1], jdo[WDATA_LSB-1:0]};

    nios2_debug_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (ctr_clear_c),
        .enable_i  (busy_c),
        .expired_o (expired_c)
    );

    // Next-state and datapath; completion beats timeout when both land on one edge.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mon_d       = mon_q;
        ready_d     = ready_q;
        error_d     = error_q;
        read_d      = read_q;
        write_d     = write_q;
        done_c      = 1'b0;
        ctr_clear_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d  = jdo[ADDR_LSB +: ADDR_W];
                    error_d = 1'b0;
                    if (jdo[RD_FLAG]) begin
                        state_d     = ST_RD_REQ;
                        read_d      = 1'b1;
                        ready_d     = 1'b0;
                        ctr_clear_c = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d     = jdo[WDATA_MSB:WDATA_LSB];
                    mon_d       = jdo[WDATA_MSB:WDATA_LSB];
                    state_d     = ST_WR_REQ;
                    write_d     = 1'b1;
                    ready_d     = 1'b0;
                    ctr_clear_c = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    state_d     = ST_RD_REQ;
                    read_d      = 1'b1;
                    ready_d     = 1'b0;
                    ctr_clear_c = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = ST_RD_DATA;
                    if (avm_readdatavalid) begin
                        mon_d  = avm_readdata;
                        done_c = 1'b1;
                    end
                end
            end
            ST_RD_DATA: begin
                if (avm_readdatavalid) begin
                    mon_d  = avm_readdata;
                    done_c = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    done_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Overrun: a strobe while busy is dropped but flagged.
        if (busy_c && any_strobe_c) begin
            error_d = 1'b1;
        end

        if (done_c) begin
            addr_d  = addr_q + ADDR_W'(1);
            ready_d = 1'b1;
            state_d = ST_IDLE;
        end else if (busy_c && expired_c) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            error_d = 1'b1;
            ready_d = 1'b1;
            mon_d   = ERR_PATTERN;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            error_q <= error_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule
